// File: rtl/dcache_ctrl_if.sv
// Bus bundle for dcache_ctrl: the CPU-side load/store signals plus the
// line-wide backing-memory handshake. The master modport is the environment
// (CPU MEM stage and backing memory). The slave modport is the cache
// controller. LW must equal 32*LINE_WORDS of the attached controller.
interface dcache_ctrl_if #(
    parameter int LW = 256
);
    logic [31:0]   cpu_addr_i;
    logic [31:0]   cpu_data_i;
    logic          cpu_memread_i;
    logic          cpu_memwrite_i;
    logic [31:0]   cpu_data_o;
    logic          cpu_stall_o;
    logic          mem_enable_o;
    logic          mem_write_o;
    logic [31:0]   mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic [LW-1:0] mem_data_i;
    logic          mem_ack_i;

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are answered combinationally. A miss stalls the pipeline while the FSM
// writes back a dirty victim line, refills the line and replays the access.
// Optional feature: define DCACHE_STATS_EN to add hit_count_o / miss_count_o.
module dcache_ctrl #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);
    localparam int LW     = 32 * LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REPLAY} state_t;

    state_t                 state_reg;
    logic [NUM_LINES-1:0]   valid_reg;
    logic [NUM_LINES-1:0]   dirty_reg;
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [LW-1:0]          data_mem [NUM_LINES];
    logic                   mem_enable_reg;
    logic                   mem_write_reg;
    logic [31:0]            mem_addr_reg;
    logic [LW-1:0]          mem_data_reg;

    // Address decode. Bits [1:0] are byte-within-word and play no role.
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;
    logic              unused_addr_bits;

    assign req_tag          = bus.cpu_addr_i[31 -: TAG_W];
    assign req_idx          = bus.cpu_addr_i[OFF_W +: IDX_W];
    assign req_word         = bus.cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = &{1'b0, bus.cpu_addr_i[1:0]};

    // Lookup of the indexed line; a store wins when both requests are high.
    logic              req;
    logic              hit;
    logic              idle_hit;
    logic              idle_miss;
    logic              ack_alloc;
    logic [LW-1:0]     cur_line;
    logic [31:0]       line_words [LINE_WORDS];

    assign req       = bus.cpu_memread_i | bus.cpu_memwrite_i;
    assign cur_line  = data_mem[req_idx];
    assign hit       = valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
    assign idle_hit  = (state_reg == IDLE) & req & hit;
    assign idle_miss = (state_reg == IDLE) & req & ~hit;
    assign ack_alloc = (state_reg == ALLOCATE) & bus.mem_ack_i;

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word_split
        assign line_words[gi] = cur_line[gi*32 +: 32];
    end

    // CPU outputs are forced low while reset is held, even with a request present.
    assign bus.cpu_stall_o = ~rst_i & ((state_reg != IDLE) | idle_miss);
    assign bus.cpu_data_o  = (~rst_i & idle_hit & ~bus.cpu_memwrite_i) ?
                             line_words[req_word] : 32'd0;

    assign bus.mem_enable_o = mem_enable_reg;
    assign bus.mem_write_o  = mem_write_reg;
    assign bus.mem_addr_o   = mem_addr_reg;
    assign bus.mem_data_o   = mem_data_reg;

    // Line storage: store-hit word merge, or whole-line refill with new tag.
    // Not reset; valid_reg decides whether a line's contents mean anything.
    always_ff @(posedge clk_i) begin
        if (idle_hit & bus.cpu_memwrite_i) begin
            data_mem[req_idx][req_word*32 +: 32] <= bus.cpu_data_i;
        end else if (ack_alloc) begin
            data_mem[req_idx] <= bus.mem_data_i;
            tag_mem[req_idx]  <= req_tag;
        end
    end

    // Miss-handling FSM with registered memory-side request outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            dirty_reg      <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_data_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (idle_hit & bus.cpu_memwrite_i) begin
                        dirty_reg[req_idx] <= 1'b1;
                    end else if (idle_miss) begin
                        mem_enable_reg <= 1'b1;
                        if (valid_reg[req_idx] & dirty_reg[req_idx]) begin
                            state_reg     <= WRITEBACK;
                            mem_write_reg <= 1'b1;
                            mem_addr_reg  <= {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_data_reg  <= cur_line;
                        end else begin
                            state_reg     <= ALLOCATE;
                            mem_write_reg <= 1'b0;
                            mem_addr_reg  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state_reg     <= ALLOCATE;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state_reg          <= REPLAY;
                        mem_enable_reg     <= 1'b0;
                        valid_reg[req_idx] <= 1'b1;
                        dirty_reg[req_idx] <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_replay_reg;

    // Hit/miss counters; the replayed access after a refill is not a new hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            post_replay_reg <= 1'b0;
            hit_count_o     <= 32'd0;
            miss_count_o    <= 32'd0;
        end else begin
            post_replay_reg <= (state_reg == REPLAY);
            if (idle_hit & ~post_replay_reg) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (idle_miss) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: hand-written sequences for refill,
// writeback and reset-abort, plus a table of directed load/store vectors.
module tb_dcache_ctrl;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if #(.LW(LW)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(.NUM_LINES(32), .LINE_WORDS(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    int total_checks = 0;
    int pass_checks  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Backing memory model: unwritten words read back as their own byte address.
    logic [LW-1:0] mem_model [logic [31:0]];

    function automatic logic [LW-1:0] mem_load(input logic [31:0] a);
        logic [LW-1:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(4 * w);
        return l;
    endfunction

    // Responder: acks the latency-th cycle a request is seen; manual_ack injects a stray pulse.
    int   latency    = 1;
    int   wait_cnt   = 0;
    bit   resp_en    = 1'b1;
    bit   manual_ack = 1'b0;

    always @(negedge clk) begin
        bus.mem_ack_i = 1'b0;
        if (manual_ack) begin
            bus.mem_data_i = {8{32'hBAD0BAD0}};
            bus.mem_ack_i  = 1'b1;
        end else if (resp_en && bus.mem_enable_o && !rst) begin
            wait_cnt++;
            if (wait_cnt >= latency) begin
                wait_cnt      = 0;
                bus.mem_ack_i = 1'b1;
                if (bus.mem_write_o) mem_model[bus.mem_addr_o] = bus.mem_data_o;
                else bus.mem_data_i = mem_load(bus.mem_addr_o);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Observations of the memory request captured while an access is stalled.
    bit          saw_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_word0;
    bit          saw_alloc;
    logic [31:0] alloc_addr;

    // Presents one access at a negedge and holds it until the stall clears.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input bit rd, input bit wr,
                             output int stalls, output logic [31:0] rdata);
        stalls    = 0;
        saw_wb    = 1'b0;
        saw_alloc = 1'b0;
        @(negedge clk);
        bus.cpu_addr_i     = addr;
        bus.cpu_data_i     = wdata;
        bus.cpu_memread_i  = rd;
        bus.cpu_memwrite_i = wr;
        #1;
        while (bus.cpu_stall_o && stalls < 200) begin
            stalls++;
            if (bus.mem_enable_o && bus.mem_write_o && !saw_wb) begin
                saw_wb   = 1'b1;
                wb_addr  = bus.mem_addr_o;
                wb_word0 = bus.mem_data_o[31:0];
            end
            if (bus.mem_enable_o && !bus.mem_write_o && !saw_alloc) begin
                saw_alloc  = 1'b1;
                alloc_addr = bus.mem_addr_o;
            end
            @(negedge clk);
            #1;
        end
        rdata = bus.cpu_data_o;
        $display("txn addr=0x%08h rd=%0d wr=%0d wdata=0x%08h stalls=%0d rdata=0x%08h",
                 addr, rd, wr, wdata, stalls, rdata);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rd;
        bit          wr;
        bit          chk_data;
        logic [31:0] exp_data;
        int          exp_stalls;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          st;
        logic [31:0] rdata;
        logic [LW-1:0] pre;

        bus.cpu_addr_i     = 32'd0;
        bus.cpu_data_i     = 32'd0;
        bus.cpu_memread_i  = 1'b0;
        bus.cpu_memwrite_i = 1'b0;

        // Zero-wait memory: clean miss = 3 stalls, dirty miss = 4 stalls.
        vecs[0]  = '{32'h0000_0084, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0,         3};
        vecs[1]  = '{32'h0000_0084, 32'h0,         1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 0};
        vecs[2]  = '{32'h0000_0080, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0080, 0};
        vecs[3]  = '{32'h0000_0484, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0484, 4};
        vecs[4]  = '{32'h0000_0084, 32'h0,         1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 3};
        vecs[5]  = '{32'h0000_0044, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 3};
        vecs[6]  = '{32'h0000_0040, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678, 0};
        vecs[7]  = '{32'h0000_0048, 32'h55AA_55AA, 1'b1, 1'b1, 1'b0, 32'h0,         0};
        vecs[8]  = '{32'h0000_004B, 32'h0,         1'b1, 1'b0, 1'b1, 32'h55AA_55AA, 0};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 3};
        vecs[10] = '{32'hFFFF_FFE0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFE0, 0};
        vecs[11] = '{32'h0000_0000, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         0};
        vecs[12] = '{32'h0000_0040, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall",      32'(bus.cpu_stall_o),  32'd0);
        check("rst_mem_enable", 32'(bus.mem_enable_o), 32'd0);
        check("rst_mem_write",  32'(bus.mem_write_o),  32'd0);
        check("rst_mem_addr",   bus.mem_addr_o,        32'd0);
        check("rst_mem_data",   bus.mem_data_o[31:0],  32'd0);
        check("rst_cpu_data",   bus.cpu_data_o,        32'd0);
        rst = 1'b0;

        // Cold read with 4-cycle memory: 1 IDLE + 4 ALLOCATE + 1 REPLAY stalls.
        pre = mem_load(32'h40);
        pre[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h40] = pre;
        latency = 4;
        do_access(32'h40, 32'h0, 1'b1, 1'b0, st, rdata);
        check("cold_stalls",     32'(st),          32'd6);
        check("cold_alloc_seen", 32'(saw_alloc),   32'd1);
        check("cold_alloc_addr", alloc_addr,       32'h40);
        check("cold_no_wb",      32'(saw_wb),      32'd0);
        check("cold_data",       rdata,            32'h40);
        do_access(32'h44, 32'h0, 1'b1, 1'b0, st, rdata);
        check("hit44_stalls",    32'(st),          32'd0);
        check("hit44_data",      rdata,            32'hDEAD_BEEF);

        // Store hit then load back.
        latency = 1;
        do_access(32'h40, 32'h1234_5678, 1'b0, 1'b1, st, rdata);
        check("st_hit_stalls",   32'(st),          32'd0);
        do_access(32'h40, 32'h0, 1'b1, 1'b0, st, rdata);
        check("ld_after_st_stalls", 32'(st),       32'd0);
        check("ld_after_st_data",   rdata,         32'h1234_5678);

        // Conflict on dirty index 2: writeback of 0x40 line, then refill of 0x440.
        do_access(32'h440, 32'h0, 1'b1, 1'b0, st, rdata);
        check("wb_stalls",       32'(st),          32'd4);
        check("wb_seen",         32'(saw_wb),      32'd1);
        check("wb_addr",         wb_addr,          32'h40);
        check("wb_word0",        wb_word0,         32'h1234_5678);
        check("wb_alloc_addr",   alloc_addr,       32'h440);
        check("wb_refill_data",  rdata,            32'h440);

`ifdef DCACHE_STATS_EN
        // Hits: 0x44 load, 0x40 store, 0x40 load; misses: 0x40, 0x440.
        @(negedge clk);
        #1;
        check("stats_hits",   hit_count,  32'd3);
        check("stats_misses", miss_count, 32'd2);
`endif

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, st, rdata);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
        end

        // Store-miss line 0x80 was written back holding the stored word.
        pre = mem_load(32'h80);
        check("store_miss_wb_word1", pre[63:32], 32'hCAFE_F00D);

        // Reset during ALLOCATE abandons the refill and invalidates everything.
        resp_en = 1'b0;
        @(negedge clk);
        bus.cpu_addr_i     = 32'h100;
        bus.cpu_memread_i  = 1'b1;
        bus.cpu_memwrite_i = 1'b0;
        #1;
        check("abort_miss_stall",  32'(bus.cpu_stall_o),  32'd1);
        @(negedge clk);
        #1;
        check("abort_alloc_en",    32'(bus.mem_enable_o), 32'd1);
        check("abort_alloc_addr",  bus.mem_addr_o,        32'h100);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rst_en",      32'(bus.mem_enable_o), 32'd0);
        check("abort_rst_stall",   32'(bus.cpu_stall_o),  32'd0);
        check("abort_rst_addr",    bus.mem_addr_o,        32'd0);
        @(negedge clk);
        bus.cpu_memread_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        manual_ack = 1'b1;
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
        @(negedge clk);
        #1;
        check("late_ack_en",       32'(bus.mem_enable_o), 32'd0);
        check("late_ack_stall",    32'(bus.cpu_stall_o),  32'd0);
        check("late_ack_addr",     bus.mem_addr_o,        32'd0);
        resp_en = 1'b1;
        do_access(32'h40, 32'h0, 1'b1, 1'b0, st, rdata);
        check("post_rst_miss_stalls", 32'(st), 32'd3);
        check("post_rst_miss_data",   rdata,   32'h1234_5678);
        do_access(32'h48, 32'h0, 1'b1, 1'b0, st, rdata);
        check("lost_store_stalls",    32'(st), 32'd0);
        check("lost_store_data",      rdata,   32'h48);

        @(negedge clk);
        bus.cpu_memread_i = 1'b0;
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end
endmodule
